// File: rtl/mips16_ctrl_pkg.sv
// Shared types and constants for the MIPS16 program load/run controller.
package mips16_ctrl_pkg;

    localparam int IMEM_DEPTH = 256;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_CYC_W  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/prog_load_run_ctrl_if.sv
// Host stream, instruction-memory write port and core control signals of the boot sequencer.
interface prog_load_run_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int CYC_W  = 16
);
    // Host stream: a word moves on any cycle where in_valid && in_ready; the host
    // must hold in_valid/in_data/in_last stable until that happens.
    logic              start;
    logic              abort;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_rst;
    logic [ADDR_W-1:0] core_pc;
    logic [ADDR_W-1:0] halt_pc;
    logic [CYC_W-1:0]  cycle_limit;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output start, abort, in_valid, in_data, in_last, core_pc, halt_pc, cycle_limit,
        input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, timeout,
               words_loaded
    );

    modport slave (
        input  start, abort, in_valid, in_data, in_last, core_pc, halt_pc, cycle_limit,
        output in_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, timeout,
               words_loaded
    );

endinterface

// File: rtl/prog_load_run_ctrl_run_cycle_counter.sv
// Saturating run-cycle counter; hit_o flags the last cycle of a non-zero budget.
module run_cycle_counter #(
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CYC_W-1:0] limit_i,
    output logic             hit_o
);

    logic [CYC_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {CYC_W{1'b1}})) begin
            cnt_q <= cnt_q + CYC_W'(1);
        end
    end

    // A zero limit means unlimited, so it never hits.
    assign hit_o = (limit_i != '0) && (cnt_q == (limit_i - CYC_W'(1)));

endmodule

// File: rtl/prog_load_run_ctrl.sv
// Boot sequencer for the 16-bit MIPS core: streams a program into instruction memory
// with the core held in reset, then runs it until the halt PC or the cycle budget.
module prog_load_run_ctrl
    import mips16_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CYC_W  = DEF_CYC_W
) (
    input  logic                clk,
    input  logic                rst,
    prog_load_run_ctrl_if.slave bus,
    output state_t              state_o
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              timeout_q, timeout_d;
    logic [ADDR_W-1:0] halt_q, halt_d;
    logic [CYC_W-1:0]  limit_q, limit_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              core_rst_q, busy_q, done_q;
    logic              xfer, cnt_clr, cnt_en, limit_hit;

    assign xfer = (state_q == LOAD) && bus.in_valid;

    run_cycle_counter #(.CYC_W(CYC_W)) u_cyc (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .limit_i(limit_q),
        .hit_o  (limit_hit)
    );

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        words_d   = words_q;
        timeout_d = timeout_q;
        halt_d    = halt_q;
        limit_d   = limit_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_d   = LOAD;
                        wr_ptr_d  = '0;
                        words_d   = '0;
                        timeout_d = 1'b0;
                        halt_d    = bus.halt_pc;
                        limit_d   = bus.cycle_limit;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        we_d     = 1'b1;
                        addr_d   = wr_ptr_q;
                        wdata_d  = bus.in_data;
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                        words_d  = words_q + (ADDR_W + 1)'(1);
                        // The last memory slot ends the load so the pointer never wraps.
                        if (bus.in_last || (wr_ptr_q == ADDR_W'(IMEM_DEPTH - 1))) begin
                            state_d = FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                end
                RUN: begin
                    cnt_en = 1'b1;
                    if (bus.core_pc == halt_q) begin
                        state_d   = DONE;
                        timeout_d = 1'b0;
                    end else if (limit_hit) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            words_q    <= '0;
            timeout_q  <= 1'b0;
            halt_q     <= '0;
            limit_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            words_q    <= words_d;
            timeout_q  <= timeout_d;
            halt_q     <= halt_d;
            limit_q    <= limit_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= (state_d != RUN);
            busy_q     <= (state_d == LOAD) || (state_d == FLUSH) || (state_d == RUN);
            done_q     <= (state_d == DONE);
        end
    end

    assign bus.in_ready     = (state_q == LOAD);
    assign bus.imem_we      = we_q;
    assign bus.imem_addr    = addr_q;
    assign bus.imem_wdata   = wdata_q;
    assign bus.core_rst     = core_rst_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.timeout      = timeout_q;
    assign bus.words_loaded = words_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_prog_load_run_ctrl.sv
// Directed bench for prog_load_run_ctrl: load, backpressure, overflow, budget, abort, async reset.
module tb_prog_load_run_ctrl;
    import mips16_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    state_t      st;
    int          total = 0;
    int          bad = 0;
    int          wr_cnt = 0;
    int          base;
    int          n;
    logic [23:0] exp_q[$];
    logic [7:0]  exp_addr;

    prog_load_run_ctrl_if bus ();

    prog_load_run_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .state_o(st)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp_v);
        end
    endtask

    // scoreboard: every imem write must match the next expected {addr, data}
    always @(negedge clk) begin : mon
        logic [23:0] e;
        if (bus.imem_we === 1'b1) begin
            wr_cnt++;
            chk("wr_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.imem_addr), 32'(e[23:16]));
                chk("wr_data", 32'(bus.imem_wdata), 32'(e[15:0]));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] halt, input logic [15:0] limit);
        bus.halt_pc     = halt;
        bus.cycle_limit = limit;
        bus.start       = 1'b1;
        exp_addr        = 8'd0;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input logic last);
        int w;
        w            = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("hs_wait", 32'(w < 20), 32'd1);
        if (w < 20) begin
            exp_q.push_back({exp_addr, d});
            exp_addr++;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = 16'h0;
        bus.in_last     = 1'b0;
        bus.core_pc     = 8'h0;
        bus.halt_pc     = 8'h0;
        bus.cycle_limit = 16'h0;
        exp_addr        = 8'h0;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(st), 32'(IDLE));
        chk("rst_core_rst", 32'(bus.core_rst), 32'd1);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_wdata", 32'(bus.imem_wdata), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_words", 32'(bus.words_loaded), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_hold", 32'(st), 32'(IDLE));

        // 4-word load, halt at PC 3, unlimited budget
        base = wr_cnt;
        start_run(8'd3, 16'd0);
        chk("t1_load", 32'(st), 32'(LOAD));
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_ready", 32'(bus.in_ready), 32'd1);
        send_word(16'h1241, 1'b0);
        send_word(16'h2242, 1'b0);
        send_word(16'hB000, 1'b0);
        send_word(16'hC03F, 1'b1);
        chk("t1_flush", 32'(st), 32'(FLUSH));
        chk("t1_flush_rst", 32'(bus.core_rst), 32'd1);
        chk("t1_flush_ready", 32'(bus.in_ready), 32'd0);
        chk("t1_words", 32'(bus.words_loaded), 32'd4);
        chk("t1_last_we", 32'(bus.imem_we), 32'd1);
        chk("t1_last_addr", 32'(bus.imem_addr), 32'd3);
        tick();
        chk("t1_run", 32'(st), 32'(RUN));
        chk("t1_core_rst", 32'(bus.core_rst), 32'd0);
        for (int p = 0; p < 4; p++) begin
            bus.core_pc = 8'(p);
            tick();
            if (p < 3) chk("t1_running", 32'(st), 32'(RUN));
        end
        bus.core_pc = 8'h0;
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_timeout", 32'(bus.timeout), 32'd0);
        chk("t1_rst_back", 32'(bus.core_rst), 32'd1);
        chk("t1_busy_low", 32'(bus.busy), 32'd0);
        chk("t1_wr_cnt", 32'(wr_cnt - base), 32'd4);

        // 10 words with host gaps; start mid-load ignored; halt_pc=0 ends after one cycle
        base = wr_cnt;
        start_run(8'd0, 16'd0);
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_word(16'h3000 + 16'(i * 17), 1'(i == 9));
            if (i == 2) begin
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
                chk("t2_start_ign", 32'(st), 32'(LOAD));
                chk("t2_words_mid", 32'(bus.words_loaded), 32'd3);
            end
        end
        chk("t2_words", 32'(bus.words_loaded), 32'd10);
        tick();
        chk("t2_run", 32'(st), 32'(RUN));
        tick();
        chk("t2_done", 32'(st), 32'(DONE));
        chk("t2_timeout", 32'(bus.timeout), 32'd0);
        chk("t2_wr_cnt", 32'(wr_cnt - base), 32'd10);
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // overflow: 256 words accepted, extras refused, then abort in RUN
        base = wr_cnt;
        start_run(8'hFF, 16'd0);
        for (int i = 0; i < 256; i++) send_word(16'(i * 7 + 1), 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hDEAD;
        chk("t3_flush", 32'(st), 32'(FLUSH));
        chk("t3_ready_low", 32'(bus.in_ready), 32'd0);
        chk("t3_words", 32'(bus.words_loaded), 32'd256);
        tick();
        chk("t3_run", 32'(st), 32'(RUN));
        chk("t3_run_ready", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        chk("t3_abort_idle", 32'(st), 32'(IDLE));
        chk("t3_abort_rst", 32'(bus.core_rst), 32'd1);
        chk("t3_abort_done", 32'(bus.done), 32'd0);
        chk("t3_abort_busy", 32'(bus.busy), 32'd0);
        chk("t3_wr_cnt", 32'(wr_cnt - base), 32'd256);

        // budget of 20 cycles, halt unreachable; reload starts at address 0
        base = wr_cnt;
        start_run(8'h80, 16'd20);
        send_word(16'hAAAA, 1'b1);
        tick();
        n = 0;
        while (bus.core_rst === 1'b0 && n < 40) begin
            n++;
            tick();
        end
        chk("t4_run_cycles", 32'(n), 32'd20);
        chk("t4_done", 32'(bus.done), 32'd1);
        chk("t4_timeout", 32'(bus.timeout), 32'd1);
        chk("t4_wr_cnt", 32'(wr_cnt - base), 32'd1);

        // halt and budget on the same cycle: halt wins
        start_run(8'd5, 16'd6);
        chk("t5_restart", 32'(st), 32'(LOAD));
        chk("t5_done_clr", 32'(bus.done), 32'd0);
        chk("t5_to_clr", 32'(bus.timeout), 32'd0);
        send_word(16'h5555, 1'b1);
        tick();
        for (int k = 1; k <= 6; k++) begin
            bus.core_pc = 8'(k - 1);
            tick();
            if (k < 6) chk("t5_running", 32'(st), 32'(RUN));
        end
        bus.core_pc = 8'h0;
        chk("t5_done", 32'(st), 32'(DONE));
        chk("t5_timeout", 32'(bus.timeout), 32'd0);

        // abort beats start
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("prio_idle", 32'(st), 32'(IDLE));
        chk("prio_busy", 32'(bus.busy), 32'd0);

        // asynchronous reset between edges during a load
        base = wr_cnt;
        start_run(8'h80, 16'd0);
        send_word(16'h7001, 1'b0);
        send_word(16'h7002, 1'b0);
        chk("t7_we_before", 32'(bus.imem_we), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h7003;
        #2;
        rst = 1'b1;
        #1;
        chk("t7_core_rst", 32'(bus.core_rst), 32'd1);
        chk("t7_we", 32'(bus.imem_we), 32'd0);
        chk("t7_state", 32'(st), 32'(IDLE));
        chk("t7_ready", 32'(bus.in_ready), 32'd0);
        chk("t7_words", 32'(bus.words_loaded), 32'd0);
        exp_q.delete();
        repeat (3) tick();
        chk("t7_no_writes", 32'(wr_cnt - base), 32'd1);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("t7_idle", 32'(st), 32'(IDLE));
        chk("t7_idle_rst", 32'(bus.core_rst), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
